// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, LCR field positions and the
// parity helper used when a character is latched for transmission.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int LCR_WLS = 0;  // two-bit field [1:0]
    localparam int LCR_STB = 2;
    localparam int LCR_PEN = 3;
    localparam int LCR_EPS = 4;
    localparam int LCR_SP  = 5;
    localparam int LCR_BRK = 6;

    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic [7:0] lcr);
        logic [7:0] mask;
        logic       x;
        case (wls)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        x = ^(data & mask);
        if (lcr[LCR_SP])
            parity_bit = ~lcr[LCR_EPS];
        else if (lcr[LCR_EPS])
            parity_bit = x;
        else
            parity_bit = ~x;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops characters from the TX FIFO and shifts them
// out on txd as start / 5-8 data bits LSB first / optional parity / 1-2 stop.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic [7:0] lcr,
    input  logic [7:0] tx_data,
    input  logic       tx_fifo_empty,
    output logic       tx_pop,
    output logic       txd,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);

    tx_state_t       state, state_nxt;
    logic [TW-1:0]   tick_cnt, tick_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [1:0]      cfg_wls;
    logic            cfg_stb;
    logic            cfg_pen;
    logic            par_q;
    logic            load;
    logic            bit_end;
    logic            txd_nxt;
    logic [2:0]      data_last;
    logic [2:0]      stop_last;
    logic            lcr_unused;

    assign lcr_unused = lcr[7];

    assign bit_end   = enable && (tick_cnt == TW'(OVERSAMPLE - 1));
    assign data_last = 3'd4 + {1'b0, cfg_wls};
    assign stop_last = cfg_stb ? 3'd1 : 3'd0;

    assign tx_pop = load && rstn;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        load      = 1'b0;
        txd_nxt   = 1'b1;
        tick_nxt  = (state != IDLE && enable) ? tick_cnt + TW'(1) : tick_cnt;

        case (state)
            IDLE: begin
                if (!tx_fifo_empty)
                    load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = shift >> 1;
                    if (bit_cnt == data_last) begin
                        bit_nxt   = 3'd0;
                        state_nxt = cfg_pen ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end)
                    state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == stop_last) begin
                        bit_nxt = 3'd0;
                        // chain straight into the next start bit when data waits
                        if (!tx_fifo_empty)
                            load = 1'b1;
                        else
                            state_nxt = IDLE;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt = START;
            tick_nxt  = '0;
            bit_nxt   = 3'd0;
            shift_nxt = tx_data;
        end

        // txd is registered from the next state so the line tracks the FSM exactly
        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            PARITY:  txd_nxt = par_q;
            default: txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= 3'd0;
            txd      <= 1'b1;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            txd      <= lcr[LCR_BRK] ? 1'b0 : txd_nxt;
        end
    end

    // Character datapath: frame config and parity are captured with the character
    always_ff @(posedge clk) begin
        shift <= shift_nxt;
        if (load) begin
            cfg_wls <= lcr[LCR_WLS +: 2];
            cfg_stb <= lcr[LCR_STB];
            cfg_pen <= lcr[LCR_PEN];
            par_q   <= parity_bit(tx_data, lcr[LCR_WLS +: 2], lcr);
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a queue-based TX FIFO model and
// per-tick capture of txd/busy for comparison against hand-written frames.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] lcr = 8'h03;
    logic [7:0] tx_data = 8'h00;
    logic       tx_fifo_empty = 1'b1;
    logic       tx_pop;
    logic       txd;
    logic       busy;

    uart_tx_serializer #(.OVERSAMPLE(OS)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .lcr           (lcr),
        .tx_data       (tx_data),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_pop        (tx_pop),
        .txd           (txd),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo[$];
    logic       txd_log[$];
    logic       busy_log[$];
    int         pop_log[$];
    int         div = 1;
    int         div_cnt = 0;
    logic       post_txd;
    logic       post_busy;
    int         n_cmp = 0;
    int         n_fail = 0;

    // One clock: present FIFO head and enable, capture txd/busy before enabled edges
    task automatic step();
        logic pop_now;
        logic en_now;
        tx_fifo_empty = (fifo.size() == 0);
        tx_data       = (fifo.size() != 0) ? fifo[0] : 8'h00;
        enable        = (div_cnt == 0);
        #1;
        pop_now = tx_pop;
        en_now  = enable;
        if (en_now) begin
            txd_log.push_back(txd);
            busy_log.push_back(busy);
        end
        @(posedge clk);
        #1;
        div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
        if (pop_now) begin
            if (fifo.size() != 0) fifo.delete(0);
            pop_log.push_back(txd_log.size());
        end
        post_txd  = txd;
        post_busy = busy;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        fifo.delete();
        rstn = 1'b0;
        div_cnt = 0;
        step();
        rstn = 1'b1;
        txd_log.delete();
        busy_log.delete();
        pop_log.delete();
        div_cnt = 0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        lcr  = 8'h03;
        fifo.push_back(8'h12);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (post_txd !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_txd cycle %0d: got %b, want 1", i, post_txd);
            end
            n_cmp++;
            if (post_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_busy cycle %0d: got %b, want 0", i, post_busy);
            end
        end
        n_cmp++;
        if (pop_log.size() != 0) begin
            n_fail++;
            $display("FAIL reset_pop: got %0d pops, want 0", pop_log.size());
        end
        fifo.delete();
        rstn = 1'b1;
        step();
        n_cmp++;
        if (post_txd !== 1'b1 || post_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: txd=%b busy=%b, want txd=1 busy=0", post_txd, post_busy);
        end
    endtask

    task automatic test_8n1();
        string exp;
        int p;
        exp = "0101010101";
        do_reset();
        div = 2;
        lcr = 8'h03;
        fifo.push_back(8'h55);
        run(360);
        n_cmp++;
        if (pop_log.size() != 1 || txd_log.size() < pop_log[0] + 161) begin
            n_fail++;
            $display("FAIL 8n1_pops: got %0d pops, %0d ticks, want 1 pop", pop_log.size(), txd_log.size());
        end else begin
            p = pop_log[0];
            for (int r = 0; r < 10 * OS; r++) begin
                logic e;
                e = (exp[r / OS] == "1");
                n_cmp++;
                if (txd_log[p + r] !== e) begin
                    n_fail++;
                    $display("FAIL 8n1_txd tick %0d: got %b, want %b", r, txd_log[p + r], e);
                end
            end
            n_cmp++;
            if (busy_log[p + 160] !== 1'b0 || txd_log[p + 160] !== 1'b1) begin
                n_fail++;
                $display("FAIL 8n1_end: busy=%b txd=%b, want busy=0 txd=1", busy_log[p + 160], txd_log[p + 160]);
            end
        end
        div = 1;
    endtask

    task automatic test_parity_7bit();
        string exp;
        int p;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            lcr = (k == 0) ? 8'h1A : 8'h0A;
            exp = (k == 0) ? "0100000101" : "0100000111";
            fifo.push_back(8'h41);
            run(200);
            n_cmp++;
            if (pop_log.size() != 1 || txd_log.size() < pop_log[0] + 161) begin
                n_fail++;
                $display("FAIL 7bit_pops case %0d: got %0d pops, want 1", k, pop_log.size());
            end else begin
                p = pop_log[0];
                for (int r = 0; r < 10 * OS; r++) begin
                    logic e;
                    e = (exp[r / OS] == "1");
                    n_cmp++;
                    if (txd_log[p + r] !== e) begin
                        n_fail++;
                        $display("FAIL 7bit_txd case %0d tick %0d: got %b, want %b", k, r, txd_log[p + r], e);
                    end
                end
                n_cmp++;
                if (busy_log[p + 160] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL 7bit_end case %0d: busy=%b, want 0", k, busy_log[p + 160]);
                end
            end
        end
    endtask

    task automatic test_5bit_stick_2stop();
        string exp;
        int p;
        exp = "011111111";
        do_reset();
        lcr = 8'h2C;
        fifo.push_back(8'h1F);
        run(180);
        n_cmp++;
        if (pop_log.size() != 1 || txd_log.size() < pop_log[0] + 145) begin
            n_fail++;
            $display("FAIL 5bit_pops: got %0d pops, want 1", pop_log.size());
        end else begin
            p = pop_log[0];
            for (int r = 0; r < 9 * OS; r++) begin
                logic e;
                e = (exp[r / OS] == "1");
                n_cmp++;
                if (txd_log[p + r] !== e) begin
                    n_fail++;
                    $display("FAIL 5bit_txd tick %0d: got %b, want %b", r, txd_log[p + r], e);
                end
            end
            n_cmp++;
            if (busy_log[p + 143] !== 1'b1) begin
                n_fail++;
                $display("FAIL 5bit_stop2_busy: busy=%b at tick 143, want 1", busy_log[p + 143]);
            end
            n_cmp++;
            if (busy_log[p + 144] !== 1'b0) begin
                n_fail++;
                $display("FAIL 5bit_end: busy=%b at tick 144, want 0", busy_log[p + 144]);
            end
        end
    endtask

    task automatic test_back_to_back();
        string exp;
        int p;
        exp = {"0101001011", "0001111001", "0111111111"};
        do_reset();
        lcr = 8'h03;
        fifo.push_back(8'hA5);
        fifo.push_back(8'h3C);
        fifo.push_back(8'hFF);
        run(520);
        n_cmp++;
        if (pop_log.size() != 3 || txd_log.size() < pop_log[0] + 481) begin
            n_fail++;
            $display("FAIL b2b_pops: got %0d pops, want 3", pop_log.size());
        end else begin
            p = pop_log[0];
            n_cmp++;
            if (pop_log[1] - pop_log[0] != 160) begin
                n_fail++;
                $display("FAIL b2b_gap1: got %0d ticks, want 160", pop_log[1] - pop_log[0]);
            end
            n_cmp++;
            if (pop_log[2] - pop_log[1] != 160) begin
                n_fail++;
                $display("FAIL b2b_gap2: got %0d ticks, want 160", pop_log[2] - pop_log[1]);
            end
            for (int r = 0; r < 30 * OS; r++) begin
                logic e;
                e = (exp[r / OS] == "1");
                n_cmp++;
                if (txd_log[p + r] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_txd tick %0d: got %b, want %b", r, txd_log[p + r], e);
                end
            end
            n_cmp++;
            if (busy_log[p + 480] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_end: busy=%b, want 0", busy_log[p + 480]);
            end
        end
    endtask

    task automatic test_break();
        string exp;
        int p;
        exp = "0111111111";
        do_reset();
        lcr = 8'h03;
        fifo.push_back(8'hFF);
        for (int i = 0; i < 200; i++) begin
            if (pop_log.size() == 1 && txd_log.size() >= pop_log[0] + 40 &&
                txd_log.size() < pop_log[0] + 80)
                lcr = 8'h43;
            else
                lcr = 8'h03;
            step();
        end
        lcr = 8'h03;
        n_cmp++;
        if (pop_log.size() != 1 || txd_log.size() < pop_log[0] + 161) begin
            n_fail++;
            $display("FAIL break_pops: got %0d pops, want 1", pop_log.size());
        end else begin
            p = pop_log[0];
            for (int r = 0; r < 10 * OS; r++) begin
                logic e;
                e = (r >= 41 && r <= 80) ? 1'b0 : (exp[r / OS] == "1");
                n_cmp++;
                if (txd_log[p + r] !== e) begin
                    n_fail++;
                    $display("FAIL break_txd tick %0d: got %b, want %b", r, txd_log[p + r], e);
                end
            end
            n_cmp++;
            if (busy_log[p + 159] !== 1'b1 || busy_log[p + 160] !== 1'b0) begin
                n_fail++;
                $display("FAIL break_schedule: busy %b%b at ticks 159/160, want 10",
                         busy_log[p + 159], busy_log[p + 160]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit done;
        int rst_idx;
        int zeros;
        done = 1'b0;
        rst_idx = 0;
        zeros = 0;
        do_reset();
        lcr = 8'h03;
        fifo.push_back(8'h00);
        for (int i = 0; i < 200; i++) begin
            if (!done && pop_log.size() == 1 && txd_log.size() == pop_log[0] + 70) begin
                rstn = 1'b0;
                step();
                rstn = 1'b1;
                done = 1'b1;
                rst_idx = txd_log.size();
                n_cmp++;
                if (post_txd !== 1'b1 || post_busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midreset_state: txd=%b busy=%b, want txd=1 busy=0", post_txd, post_busy);
                end
            end else begin
                step();
            end
        end
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL midreset_reached: reset point never hit, pops=%0d", pop_log.size());
        end else begin
            for (int j = rst_idx; j < txd_log.size(); j++)
                if (txd_log[j] !== 1'b1 || busy_log[j] !== 1'b0) zeros++;
            n_cmp++;
            if (zeros != 0) begin
                n_fail++;
                $display("FAIL midreset_idle: %0d non-idle ticks after reset, want 0", zeros);
            end
        end
        n_cmp++;
        if (pop_log.size() != 1) begin
            n_fail++;
            $display("FAIL midreset_pops: got %0d pops, want 1", pop_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity_7bit();
        test_5bit_stick_2stop();
        test_back_to_back();
        test_break();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
